ecall_io_ctrl: RTL and testbench
================================

Name: ecall_io_ctrl

Overview:
- Sequences ecall-based I/O for the single-cycle RISC-V core.
- The decoder flags ecall (instruction 0x00000073). This block inspects a7 and services the call:
  - read services (a7=0..3) stall the core until a debounced confirm press, then write switch data back to a0;
  - write services (a7=4..5) latch a0 into the LED or seven-segment registers in one cycle.
- Sits between the decoder/register file and the board I/O pins.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required before the confirm level is accepted (board build overrides to 200000).
- TIMEOUT_CYCLES, 1024: read-wait limit, used only with ECALL_TIMEOUT_EN.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- ecall  input  1  current instruction is ecall
- a7  input  32  register a7 value (service number)
- a0  input  32  register a0 value (write payload)
- switch_in  input  16  raw board switches
- confirm_btn  input  1  raw confirm button, active-high
- io_stall  output  1  hold PC and suppress all register writes
- io_wen  output  1  one-cycle strobe: write io_rdata into a0
- io_rdata  output  32  read-service result
- led_out  output  16  LED register
- seg_out  output  32  seven-segment display value register

Behaviour:
- Reset and clock: clock is the single clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, io_wen=0, io_rdata=0, led_out=0, seg_out=0, debounce counter=0, stable level=0, both sync flops=0. io_stall is then 0.
- Debounce:
  - confirm_btn passes through a 2-flop synchroniser.
  - The counter increments while the synced value differs from the stable level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
  - press = stable level 0->1 (one-cycle pulse). A held button never produces a second press.
- FSM states:
  - IDLE:
    - ecall with a7 in 0..3: latch the service code, go to WAIT_PRESS.
    - ecall with a7=4: led_out<=a0[15:0]. a7=5: seg_out<=a0. Both complete at that edge with no stall; stay in IDLE.
    - a7>5 or a7 bit31 set: no-op, no stall.
  - WAIT_PRESS:
    - On press: io_rdata<=service result, go to WRITEBACK.
    - A press already pending in the same cycle as the ecall is ignored; only presses arriving while in WAIT_PRESS count.
  - WRITEBACK: io_wen=1 and io_stall=0 for exactly one cycle; the core commits a0 and advances PC at this edge. Always go to IDLE, even though ecall is still visible this cycle.
- Service results:
  - 0: {16'b0, sw}
  - 1: sign-extended sw[15]
  - 2: {24'b0, sw[7:0]}
  - 3: {31'b0, sw[0]}
  - sw is sampled on the press cycle.
- io_stall (combinational): (IDLE && ecall && a7 in 0..3) || WAIT_PRESS.
- io_wen is registered; it is high only in WRITEBACK.
- Latency: read = 1 + wait + 1 cycles; write = 0 extra cycles.
- Reset mid-operation: FSM returns to IDLE at once, no io_wen, io_rdata cleared, LED/seg registers cleared.
- Back-to-back reads: each needs a new release+press; a held button stalls the second read.

Optional Feature:
- Macro: ECALL_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering WAIT_PRESS and increments each WAIT_PRESS cycle.
  - At TIMEOUT_CYCLES-1 without a press: io_rdata<=32'hFFFFFFFF, go to WRITEBACK.
  - A press in the same cycle as the timeout wins (normal data).
- Undefined: no counter; WAIT_PRESS waits indefinitely.

Test Plan:
- Reset mid-wait: reset asserted while in WAIT_PRESS -> next cycle state=IDLE, io_stall=0, io_wen never pulses, led_out=0, seg_out=0.
- Read zero-extend: ecall, a7=0, sw=0xA5C3, clean press after 5 cycles -> io_stall high until press is debounced, then io_wen=1 for exactly one cycle with io_rdata=0x0000A5C3 and io_stall=0.
- Read sign-extend: a7=1, sw=0x8001 -> io_rdata=0xFFFF8001. Same press with a7=3 -> 0x00000001.
- Write services: ecall a7=4, a0=0x1234BEEF -> led_out=0xBEEF next edge, io_stall never high. a7=5 -> seg_out=0x1234BEEF.
- Bounce and hold: button toggles every 3 cycles for 40 cycles, then held; second read issued while held -> exactly one io_wen, second read stalls until release+press. a7=9 -> no stall, no outputs change.
- ECALL_TIMEOUT_EN (TIMEOUT_CYCLES=8): read with no press -> io_wen after 8 wait cycles with io_rdata=0xFFFFFFFF.

Source files
------------

// File: rtl/ecall_io_ctrl_if.sv
// Core-side ecall handshake: decoder/register-file view of the I/O sequencer.
interface ecall_io_ctrl_if;
  logic        ecall;
  logic [31:0] a7;
  logic [31:0] a0;
  logic        io_stall;
  logic        io_wen;
  logic [31:0] io_rdata;

  modport master (
    output ecall, a7, a0,
    input  io_stall, io_wen, io_rdata
  );

  modport slave (
    input  ecall, a7, a0,
    output io_stall, io_wen, io_rdata
  );
endinterface

// File: rtl/ecall_io_ctrl.sv
// Ecall I/O sequencer: debounced-confirm read services and single-cycle LED/7-seg writes.
// Optional read-wait timeout enabled by defining ECALL_TIMEOUT_EN.
module ecall_io_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  ecall_io_ctrl_if.slave      core,
  input  logic [15:0]         switch_in,
  input  logic                confirm_btn,
  output logic [15:0]         led_out,
  output logic [31:0]         seg_out
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ecall_io_ctrl: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must both be at least 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StWaitPress,
    StWriteback
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  svc_q, svc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic        wen_q, wen_d;
  logic        stall;

  logic           sync1_q, sync2_q;
  logic           stable_q, stable_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           press;

  logic        rd_req;
  logic [31:0] svc_result;

`ifdef ECALL_TIMEOUT_EN
  localparam int unsigned TmW = $clog2(TIMEOUT_CYCLES);
  logic [TmW-1:0] wcnt_q, wcnt_d;
  logic           timeout;
`endif

  // Confirm button: two-flop synchroniser followed by a level debouncer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= confirm_btn;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Press is the cycle the stable level rises, so a held button yields one press only.
  assign press = ~stable_q & stable_d;

  assign rd_req = core.ecall && (core.a7[31:2] == 30'd0);

  always_comb begin
    case (svc_q)
      2'd0:    svc_result = {16'h0000, switch_in};
      2'd1:    svc_result = {{16{switch_in[15]}}, switch_in};
      2'd2:    svc_result = {24'h000000, switch_in[7:0]};
      default: svc_result = {31'h0, switch_in[0]};
    endcase
  end

`ifdef ECALL_TIMEOUT_EN
  assign timeout = (wcnt_q == TmW'(TIMEOUT_CYCLES - 1));
  assign wcnt_d  = (state_q == StWaitPress) ? wcnt_q + 1'b1 : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      svc_q   <= 2'd0;
      rdata_q <= '0;
      led_q   <= '0;
      seg_q   <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      svc_q   <= svc_d;
      rdata_q <= rdata_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    svc_d   = svc_q;
    rdata_d = rdata_q;
    led_d   = led_q;
    seg_d   = seg_q;
    wen_d   = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          stall   = 1'b1;
          svc_d   = core.a7[1:0];
          state_d = StWaitPress;
        end else if (core.ecall && core.a7 == 32'd4) begin
          led_d = core.a0[15:0];
        end else if (core.ecall && core.a7 == 32'd5) begin
          seg_d = core.a0;
        end
      end
      StWaitPress: begin
        stall = 1'b1;
        if (press) begin
          rdata_d = svc_result;
          wen_d   = 1'b1;
          state_d = StWriteback;
`ifdef ECALL_TIMEOUT_EN
        end else if (timeout) begin
          rdata_d = 32'hFFFF_FFFF;
          wen_d   = 1'b1;
          state_d = StWriteback;
`endif
        end
      end
      // Ecall is still visible here; returning to idle unconditionally avoids a re-trigger.
      StWriteback: state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  assign core.io_stall = stall;
  assign core.io_wen   = wen_q;
  assign core.io_rdata = rdata_q;
  assign led_out       = led_q;
  assign seg_out       = seg_q;

endmodule

// File: tb/tb_ecall_io_ctrl.sv
// Bench for ecall_io_ctrl: directed stimulus, cycle compare against a behavioural model.
module tb_ecall_io_ctrl;

  localparam int D = 16;
  localparam int T = 8;

  logic        clock;
  logic        reset;
  logic [15:0] switch_in;
  logic        confirm_btn;
  logic [15:0] led_out;
  logic [31:0] seg_out;

  ecall_io_ctrl_if cif ();

  ecall_io_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .core        (cif),
    .switch_in   (switch_in),
    .confirm_btn (confirm_btn),
    .led_out     (led_out),
    .seg_out     (seg_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit run   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] svc_result(input logic [1:0] s, input logic [15:0] sw);
    logic [31:0] v;
    v = 32'(sw);
    case (s)
      2'd0:    return v;
      2'd1:    return sw[15] ? (v | 32'hFFFF_0000) : v;
      2'd2:    return v & 32'h0000_00FF;
      default: return v & 32'h0000_0001;
    endcase
  endfunction

  // Model: raw button history gives the synchronised view; the stable level flips
  // once the last D synchronised samples all disagree with it.
  bit          raw_q[$];
  bit          s2_q[$];
  bit          m_stable = 1'b0;
  bit          m_wait   = 1'b0;
  bit          m_wb     = 1'b0;
  logic [1:0]  m_svc    = 2'd0;
  logic [31:0] m_rdata  = '0;
  logic [15:0] m_led    = '0;
  logic [31:0] m_seg    = '0;
  int          m_wcnt   = 0;

  always @(posedge clock or posedge reset) begin : model
    bit s2, flip, press;
    if (reset) begin
      raw_q.delete();
      s2_q.delete();
      m_stable = 1'b0;
      m_wait   = 1'b0;
      m_wb     = 1'b0;
      m_svc    = 2'd0;
      m_rdata  = '0;
      m_led    = '0;
      m_seg    = '0;
      m_wcnt   = 0;
    end else begin
      s2 = (raw_q.size() == 2) ? raw_q[0] : 1'b0;
      s2_q.push_back(s2);
      if (s2_q.size() > D) void'(s2_q.pop_front());
      flip = (s2_q.size() == D);
      foreach (s2_q[i]) if (s2_q[i] == m_stable) flip = 1'b0;
      press = flip && !m_stable;
      if (flip) m_stable = !m_stable;
      raw_q.push_back(confirm_btn);
      if (raw_q.size() > 2) void'(raw_q.pop_front());

      if (m_wb) begin
        m_wb = 1'b0;
      end else if (m_wait) begin
        if (press) begin
          m_rdata = svc_result(m_svc, switch_in);
          m_wait  = 1'b0;
          m_wb    = 1'b1;
        end
`ifdef ECALL_TIMEOUT_EN
        else if (m_wcnt == T - 1) begin
          m_rdata = 32'hFFFF_FFFF;
          m_wait  = 1'b0;
          m_wb    = 1'b1;
        end else begin
          m_wcnt++;
        end
`endif
      end else if (cif.ecall) begin
        if (cif.a7 < 32'd4) begin
          m_wait = 1'b1;
          m_svc  = cif.a7[1:0];
          m_wcnt = 0;
        end else if (cif.a7 == 32'd4) begin
          m_led = cif.a0[15:0];
        end else if (cif.a7 == 32'd5) begin
          m_seg = cif.a0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (run) begin
      chk("stall", 32'(cif.io_stall),
          32'(m_wait || (!m_wb && cif.ecall && cif.a7 < 32'd4)));
      chk("wen",   32'(cif.io_wen), 32'(m_wb));
      chk("rdata", cif.io_rdata, m_rdata);
      chk("led",   32'(led_out), 32'(m_led));
      chk("seg",   seg_out, m_seg);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_write(input logic [31:0] svc, input logic [31:0] val);
    cif.ecall = 1'b1;
    cif.a7    = svc;
    cif.a0    = val;
    #1 chk("wr_stall", 32'(cif.io_stall), 32'd0);
    tick();
    cif.ecall = 1'b0;
  endtask

  // Waits (bounded) for the writeback strobe; returns cycles waited or -1.
  task automatic wait_wen(input int limit, output int n);
    n = 0;
    while (!cif.io_wen && n < limit) begin
      tick();
      n++;
    end
    if (!cif.io_wen) begin
      chk("wen_wait_expired", 32'(n), 32'(limit + 1));
      n = -1;
    end
  endtask

  task automatic do_read(input logic [31:0] svc, input logic [15:0] sw, input logic [31:0] exp);
    int n;
    cif.ecall = 1'b1;
    cif.a7    = svc;
    switch_in = sw;
    #1 chk("rd_stall_issue", 32'(cif.io_stall), 32'd1);
    repeat (5) tick();
    confirm_btn = 1'b1;
    wait_wen(200, n);
    if (n >= 0) begin
      chk("rd_data", cif.io_rdata, exp);
      chk("rd_wb_stall", 32'(cif.io_stall), 32'd0);
      tick();
      chk("rd_wen_once", 32'(cif.io_wen), 32'd0);
    end
    cif.ecall   = 1'b0;
    confirm_btn = 1'b0;
    repeat (24) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, wens;
    reset       = 1'b1;
    cif.ecall   = 1'b0;
    cif.a7      = '0;
    cif.a0      = '0;
    switch_in   = '0;
    confirm_btn = 1'b0;
    tick();
    run = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("rst_led",   32'(led_out), 32'd0);
    chk("rst_seg",   seg_out, 32'd0);
    chk("rst_rdata", cif.io_rdata, 32'd0);
    chk("rst_wen",   32'(cif.io_wen), 32'd0);
    chk("rst_stall", 32'(cif.io_stall), 32'd0);
    tick();

    do_write(32'd4, 32'h1234_BEEF);
    chk("led_write", 32'(led_out), 32'h0000_BEEF);
    do_write(32'd5, 32'h1234_BEEF);
    chk("seg_write", seg_out, 32'h1234_BEEF);

    do_write(32'd9, 32'hDEAD_0000);
    do_write(32'h8000_0004, 32'hDEAD_0001);
    chk("noop_led", 32'(led_out), 32'h0000_BEEF);
    chk("noop_seg", seg_out, 32'h1234_BEEF);
    chk("noop_wen", 32'(cif.io_wen), 32'd0);
    tick();

`ifndef ECALL_TIMEOUT_EN
    do_read(32'd0, 16'hA5C3, 32'h0000_A5C3);
    do_read(32'd1, 16'h8001, 32'hFFFF_8001);
    do_read(32'd3, 16'h8001, 32'h0000_0001);
    do_read(32'd2, 16'h12F4, 32'h0000_00F4);

    // Bouncing button is filtered; a held button then serves only one read.
    cif.ecall = 1'b1;
    cif.a7    = 32'd0;
    switch_in = 16'h0F0F;
    wens      = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) confirm_btn = ~confirm_btn;
      tick();
      if (cif.io_wen) wens++;
    end
    chk("bounce_no_wen", 32'(wens), 32'd0);
    confirm_btn = 1'b1;
    wait_wen(100, n);
    if (n >= 0) begin
      wens++;
      chk("hold_rd_data", cif.io_rdata, 32'h0000_0F0F);
    end
    tick();
    cif.ecall = 1'b0;
    tick();
    cif.ecall = 1'b1;
    cif.a7    = 32'd2;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cif.io_wen) wens++;
    end
    chk("hold_one_wen", 32'(wens), 32'd1);
    chk("hold_stall",   32'(cif.io_stall), 32'd1);
    confirm_btn = 1'b0;
    repeat (30) tick();
    confirm_btn = 1'b1;
    wait_wen(100, n);
    if (n >= 0) chk("repress_rd_data", cif.io_rdata, 32'h0000_000F);
    tick();
    cif.ecall   = 1'b0;
    confirm_btn = 1'b0;
    repeat (24) tick();
`else
    cif.ecall = 1'b1;
    cif.a7    = 32'd0;
    switch_in = 16'hA5C3;
    wait_wen(50, n);
    chk("to_latency", 32'(n), 32'd9);
    chk("to_data", cif.io_rdata, 32'hFFFF_FFFF);
    tick();
    cif.ecall = 1'b0;
    repeat (4) tick();
`endif

    // Reset while waiting for a press.
    cif.ecall   = 1'b1;
    cif.a7      = 32'd0;
    confirm_btn = 1'b1;
    repeat (5) tick();
    reset     = 1'b1;
    cif.ecall = 1'b0;
    #1;
    chk("rstw_stall", 32'(cif.io_stall), 32'd0);
    chk("rstw_led",   32'(led_out), 32'd0);
    chk("rstw_seg",   seg_out, 32'd0);
    chk("rstw_rdata", cif.io_rdata, 32'd0);
    tick();
    reset = 1'b0;
    wens  = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cif.io_wen) wens++;
    end
    chk("rstw_no_wen", 32'(wens), 32'd0);
    confirm_btn = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
